// File: rtl/sign_packer.sv
// Sign packer: gathers a stream of single sign bits LSB-first into DW-bit words
// and queues completed words, tagged with a last-of-hypervector flag, in a small
// output FIFO. Backpressure is derived from registered occupancy only; any sign
// bit offered while the FIFO is full is dropped and flagged in a sticky overflow
// bit.
module sign_packer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sign_valid,
    input  logic          sign_bit,
    input  logic          sign_last,
    output logic          in_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          overflow
);

    localparam int unsigned CW = $clog2(DW);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CntMax = CW'(DW - 1);
    localparam logic [OW-1:0] OccFull = OW'(DEPTH);

    // Each FIFO entry holds {last, word}.
    typedef logic [DW:0] entry_t;

    logic [DW-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          overflow_q, overflow_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    logic          accept;
    logic          pop;
    logic          push;
    logic [DW-1:0] merged;

    // Handshake status comes straight from registered state.
    always_comb begin
        in_ready = (occ_q < OccFull);
        m_valid  = (occ_q != '0);
        m_data   = mem_q[rd_ptr_q][DW-1:0];
        m_last   = mem_q[rd_ptr_q][DW];
        overflow = overflow_q;
    end

    // Bit assembly: merge the accepted bit and decide whether the word closes.
    always_comb begin
        accept  = sign_valid && in_ready;
        pop     = m_valid && m_ready;
        push    = 1'b0;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        // Upper bits of shift_q are always zero, so an early close is zero-filled.
        merged  = shift_q | ({{(DW-1){1'b0}}, sign_bit} << cnt_q);
        if (accept) begin
            if (sign_last || (cnt_q == CntMax)) begin
                push    = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = merged;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // FIFO bookkeeping and sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = {sign_last, merged};
            // Pointer width equals log2(DEPTH), so the increment wraps on its own.
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Push only happens below full, so occupancy never exceeds DEPTH.
        occ_d = occ_q + OW'(push) - OW'(pop);
        if (sign_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    // State register; storage is cleared too so m_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_sign_packer.sv
// Bench for sign_packer: directed scenarios plus a long random run. A reference
// model packs accepted bits into words with plain queue arithmetic and pushes
// the expected words into a scoreboard; a forked monitor pops and compares on
// every output handshake.
module tb_sign_packer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sign_valid = 1'b0;
    logic          sign_bit = 1'b0;
    logic          sign_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          overflow;

    sign_packer #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sign_valid (sign_valid),
        .sign_bit   (sign_bit),
        .sign_last  (sign_last),
        .in_ready   (in_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [DW:0] exp_q [$];   // {last, word}
    logic        bits_q [$];  // bits of the word being assembled
    int          m_occ = 0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every word the DUT hands over against the scoreboard.
    task automatic monitor();
        logic [DW-1:0] prev_data = '0;
        logic          prev_stall = 1'b0;
        logic [DW:0]   e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("stall_stable", 64'(m_data), 64'(prev_data));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got %0h expected none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", 64'(m_data), 64'(e[DW-1:0]));
                        chk("m_last", 64'(m_last), 64'(e[DW]));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    endtask

    // One clock cycle: apply inputs, check status at negedge, advance the model.
    task automatic step(input logic sv, input logic sb, input logic sl, input logic mr);
        logic        can_take;
        logic        push;
        logic        pop;
        logic [DW:0] w;
        sign_valid = sv;
        sign_bit   = sb;
        sign_last  = sl;
        m_ready    = mr;
        @(negedge clk);
        can_take = (m_occ < int'(DEPTH));
        chk("in_ready", 64'(in_ready), 64'(can_take));
        chk("m_valid", 64'(m_valid), 64'(m_occ > 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        push = 1'b0;
        pop  = (m_occ > 0) && mr;
        if (sv && !can_take) m_ovf = 1'b1;
        if (sv && can_take) begin
            bits_q.push_back(sb);
            if (sl || bits_q.size() == int'(DW)) begin
                w = '0;
                for (int i = 0; i < bits_q.size(); i++) w[i] = bits_q[i];
                w[DW] = sl;
                exp_q.push_back(w);
                bits_q.delete();
                push = 1'b1;
            end
        end
        m_occ = m_occ + int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sign_valid = 1'b0;
        m_ready    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        bits_q.delete();
        m_occ = 0;
        m_ovf = 1'b0;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_overflow", 64'(overflow), 64'(0));
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, mr);
    endtask

    initial begin
        fork
            monitor();
        join_none
        #1;
        do_reset();

        // Alternating 1,0 over 32 bits closing with last -> 0x55555555.
        for (int i = 0; i < 32; i++) step(1'b1, (i % 2) == 0, i == 31, 1'b1);
        idle(3, 1'b1);

        // Short word closed early, then the counter restarts at bit 0.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 4, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Fill the FIFO with four all-ones words under stall, then overflow.
        for (int i = 0; i < 4 * 32; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf_set", 64'(overflow), 64'(1));
        idle(6, 1'b1);

        // Full FIFO: a closing bit offered on the pop edge is refused, then taken.
        do_reset();
        for (int i = 0; i < 4 * 32; i++) step(1'b1, i[0], 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("refill_full", 64'(in_ready), 64'(0));
        idle(6, 1'b1);

        // Partial word discarded by reset.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, i == 31, 1'b1);
        idle(3, 1'b1);
        chk("no_ovf_after_rst", 64'(overflow), 64'(0));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 10) < 6, $urandom_range(0, 1) == 1,
                 ($urandom % 20) == 0, $urandom_range(0, 1) == 1);
        end
        idle(DEPTH + 3, 1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
